instr_mem_arbiter: RTL and testbench
====================================

Name: instr_mem_arbiter

Overview:
- Shares one instruction-memory port (req/gnt/rvalid protocol) between two fetch masters.
  - Master 0: core IF stage.
  - Master 1: trace/debug fetcher.
- Round-robin arbitration.
- Holds the selection while a request waits for grant.
- Tracks up to MAX_OUTSTANDING in-order transactions, so each rvalid/rdata returns to the master that issued it.
- Sits between the fetch masters and instruction_memory.

Parameters:
- ADDR_WIDTH, 32, address width (`ADDR_WIDTH)
- DATA_WIDTH, 32, read-data width (`DATA_WIDTH)
- MAX_OUTSTANDING, 2, max granted-but-unanswered transactions (power of 2, >=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- m0_req  in  1  master 0 request
- m0_addr  in  ADDR_WIDTH  master 0 address
- m0_gnt  out  1  master 0 grant
- m0_rvalid  out  1  master 0 response valid
- m0_rdata  out  DATA_WIDTH  master 0 read data
- m1_req, m1_addr, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1
- mem_req  out  1  request to memory
- mem_addr  out  ADDR_WIDTH  address to memory
- mem_gnt  in  1  memory grant
- mem_rvalid  in  1  memory response valid
- mem_rdata  in  DATA_WIDTH  memory read data
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current outstanding count
- err_o  out  1  sticky protocol error

Behaviour:
- Reset state: pointer=master 0, state=IDLE, ID FIFO empty, count=0, err_o=0.
  - All m*_gnt, m*_rvalid, mem_req = 0.
  - m*_rdata and mem_addr = 0.
- Request path is combinational: mem_req/mem_addr come from the selected master in the same cycle. m*_gnt = mem_gnt & mem_req & (sel==m). Zero added latency.
- Stall: when count==MAX_OUTSTANDING, mem_req=0 and both gnts=0.
- Selection:
  - One requester: that requester.
  - Both requesting: the master at the RR pointer.
  - Pointer moves to the other master on every accepted grant.
- FSM:
  - IDLE: a selected request is presented. mem_gnt -> stay IDLE, push ID. No gnt -> LOCKED, sel latched.
  - LOCKED: sel is fixed regardless of the other master or the pointer. The latched master's req is required to stay high (it may not be withdrawn). mem_gnt -> push ID, go to IDLE.
- Responses are in order:
  - mem_rvalid pops the FIFO head ID and asserts that master's rvalid in the same cycle.
  - The addressed master's rdata = mem_rdata. The other master's rdata = 0.
- Simultaneous grant and rvalid in one cycle: push and pop both happen; count unchanged. Allowed even when count==MAX_OUTSTANDING-… only if not stalled.
- mem_rvalid with FIFO empty: discarded, no m*_rvalid, err_o set (stays set until rst).
- LOCKED master drops req before gnt: err_o set, FSM returns to IDLE, no push.
- Reset mid-operation clears the FIFO. Late rvalids after reset therefore set err_o.
- Count arithmetic: count_next = count + push - pop. Never exceeds MAX_OUTSTANDING; never goes negative.
- FIFO pointers are $clog2 wide and wrap modulo MAX_OUTSTANDING.

Decomposition:
- Into ryuki_datatypes:
  - typedef master_id_t (1 bit).
  - enum arb_state_t {IDLE, LOCKED}.
- Widths come from ryuki_defines.
- One sub-module: arb_id_fifo.
  - Parameters: WIDTH, DEPTH.
  - Ports: push/pop, din/dout, count, full, empty.
  - Synchronous reset.
  - Same-cycle push+pop is legal.

Test Plan:
- Only m0 requests 0x80 then 0x0 with 1-cycle gnt and rvalid the next cycle -> m0_gnt in the request cycle, m0_rvalid one cycle later, rdata matches memory, m1_* stays 0, outstanding_o returns to 0.
- Both masters request continuously (m0 0x4, m1 0x48) -> grants alternate m0, m1, m0, m1, … starting with m0 after reset; responses route to the matching master in order.
- Memory withholds gnt 3 cycles while m0 is LOCKED and m1 raises req -> mem_addr stays 0x4 all 3 cycles; m0 granted first, then m1 on the next opportunity.
- MAX_OUTSTANDING=2, two grants with rvalid held off -> outstanding_o=2, mem_req=0 while stalled; first rvalid re-enables mem_req the same cycle.
- Grant and rvalid in the same cycle at count=1 -> count stays 1, correct master gets rvalid, new ID is queued behind.
- mem_rvalid with no transaction outstanding, and assertion of rst mid-transaction -> err_o=1, no m*_rvalid; err_o clears only on rst.

Source files
------------

// File: rtl/instr_mem_arbiter_pkg.sv
// Shared types and default widths for the instruction-memory arbiter.
package instr_mem_arbiter_pkg;

    localparam int DEFAULT_ADDR_WIDTH      = 32;
    localparam int DEFAULT_DATA_WIDTH      = 32;
    localparam int DEFAULT_MAX_OUTSTANDING = 2;

    // Identifies which fetch master owns a transaction: 0 = IF stage, 1 = trace/debug.
    typedef logic master_id_t;

    // IDLE: free to pick a requester; LOCKED: a request is waiting for mem grant.
    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

    // Round-robin helper: the master that gets priority after m is served.
    function automatic master_id_t other_master(master_id_t m);
        return ~m;
    endfunction

endpackage

// File: rtl/instr_mem_arbiter_if.sv
// req/gnt/rvalid instruction-fetch bus. "master" issues requests,
// "slave" answers them.
interface instr_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/instr_mem_arbiter_id_fifo.sv
// Small in-order FIFO of master IDs for granted-but-unanswered fetches.
// The head is read combinationally so a response can be routed in the
// same cycle its rvalid arrives. Push and pop in one cycle are legal,
// including when full (the slot being freed is the slot being written).
module arb_id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap modulo DEPTH; DEPTH is a power of two, so natural overflow does it.
    function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
        if (DEPTH == 1) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign dout    = mem_reg[rd_ptr_reg];
    // Overflow/underflow requests are dropped so the count stays within 0..DEPTH.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Storage array: no reset so it maps onto plain RAM/LUT storage.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/instr_mem_arbiter.sv
// Two-master round-robin arbiter in front of the instruction memory.
// The request path is purely combinational (zero added latency); the FSM
// only remembers a waiting selection, the RR pointer and the sticky error.
// An ID FIFO returns each in-order response to the master that issued it.
module instr_mem_arbiter
    import instr_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic                             clk,
    input  logic                             rst,
    instr_mem_arbiter_if.slave               m0,
    instr_mem_arbiter_if.slave               m1,
    instr_mem_arbiter_if.master              mem,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
    output logic                             err_o
);
    arb_state_t state_reg;
    master_id_t ptr_reg;
    master_id_t lock_sel_reg;
    logic       err_reg;

    master_id_t sel;
    logic       sel_req;
    logic       stall;
    logic       req_c;
    logic       grant;
    logic       pop;

    master_id_t                      head_id;
    logic [$clog2(MAX_OUTSTANDING):0] fifo_count;
    logic                            fifo_full;
    logic                            fifo_empty;

    // Selection and request gating. A pending response frees a slot this
    // cycle, so a full FIFO only stalls when no rvalid is arriving.
    always_comb begin
        stall = fifo_full && !mem.rvalid;
        if (state_reg == LOCKED) begin
            sel = lock_sel_reg;
        end else if (m0.req && m1.req) begin
            sel = ptr_reg;
        end else if (m1.req) begin
            sel = 1'b1;
        end else begin
            sel = 1'b0;
        end
        sel_req = sel ? m1.req : m0.req;
        req_c   = !rst && !stall && sel_req;
        grant   = req_c && mem.gnt;
        pop     = !rst && mem.rvalid && !fifo_empty;
    end

    assign mem.req   = req_c;
    assign mem.addr  = req_c ? (sel ? m1.addr : m0.addr) : '0;

    assign m0.gnt    = grant && (sel == 1'b0);
    assign m1.gnt    = grant && (sel == 1'b1);

    // Responses go to the FIFO head; unmatched rvalids are dropped here.
    assign m0.rvalid = pop && (head_id == 1'b0);
    assign m1.rvalid = pop && (head_id == 1'b1);
    assign m0.rdata  = m0.rvalid ? mem.rdata : '0;
    assign m1.rdata  = m1.rvalid ? mem.rdata : '0;

    assign outstanding_o = fifo_count;
    assign err_o         = err_reg;

    arb_id_fifo #(
        .WIDTH ($bits(master_id_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .pop   (pop),
        .din   (sel),
        .dout  (head_id),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Arbitration FSM: holds a waiting selection, advances the RR pointer
    // on each accepted grant and latches protocol errors until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= 1'b0;
            lock_sel_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            if (grant) begin
                ptr_reg <= other_master(sel);
            end
            if (mem.rvalid && fifo_empty) begin
                err_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (req_c && !mem.gnt) begin
                        state_reg    <= LOCKED;
                        lock_sel_reg <= sel;
                    end
                end
                LOCKED: begin
                    if (!sel_req) begin
                        // Withdrawn request: abandon it without queueing an ID.
                        err_reg   <= 1'b1;
                        state_reg <= IDLE;
                    end else if (mem.gnt) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed-vector bench for instr_mem_arbiter: a queue-based model checks
// every output every cycle, and hand-written literals pin key cycles.
module tb_instr_mem_arbiter;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int MAX_OUT = 2;

    typedef struct {
        bit          rst;
        bit          r0;
        logic [31:0] a0;
        bit          r1;
        logic [31:0] a1;
        bit          g;
        bit          rv;
        logic [31:0] rd;
        bit          chk;
        bit [1:0]    egnt;
        bit [1:0]    erv;
        int          ecnt;
        bit          eerr;
        bit          ereq;
        logic [31:0] eaddr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] outstanding_o;
    logic       err_o;

    instr_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_bus ();
    instr_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_bus ();
    instr_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

    instr_mem_arbiter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .m0            (m0_bus),
        .m1            (m1_bus),
        .mem           (mem_bus),
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    vec_t vecs[$];
    vec_t cur;
    bit   active = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Model state: queue of owners of outstanding fetches, RR pointer,
    // master waiting for grant (-1 = none), sticky error.
    int q[$];
    int rr_m = 0;
    int lock_m = -1;
    bit err_m = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(bit r, bit r0, logic [31:0] a0, bit r1, logic [31:0] a1,
                       bit g, bit rv, logic [31:0] rd, bit chk, bit [1:0] egnt,
                       bit [1:0] erv, int ecnt, bit eerr, bit ereq, logic [31:0] eaddr);
        vec_t v;
        v.rst = r; v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
        v.g = g; v.rv = rv; v.rd = rd; v.chk = chk; v.egnt = egnt;
        v.erv = erv; v.ecnt = ecnt; v.eerr = eerr; v.ereq = ereq; v.eaddr = eaddr;
        vecs.push_back(v);
    endtask

    task automatic idle(bit r, int ecnt, bit eerr);
        add(r, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, ecnt, eerr, 0, 0);
    endtask

    // Compare process: outputs are stable by the falling edge.
    always @(negedge clk) begin
        int sel;
        bit sreq, full_m, req_m, gnt_m, pop_m;
        int head;
        bit rv0, rv1;
        logic [31:0] addr_m;
        if (active) begin
            full_m = (q.size() == MAX_OUT) && !cur.rv;
            if (lock_m >= 0)          sel = lock_m;
            else if (cur.r0 && cur.r1) sel = rr_m;
            else if (cur.r1)          sel = 1;
            else                      sel = 0;
            sreq   = (sel == 1) ? cur.r1 : cur.r0;
            req_m  = !cur.rst && !full_m && sreq;
            addr_m = req_m ? ((sel == 1) ? cur.a1 : cur.a0) : 32'h0;
            gnt_m  = req_m && cur.g;
            pop_m  = !cur.rst && cur.rv && (q.size() > 0);
            head   = pop_m ? q[0] : -1;
            rv0    = pop_m && (head == 0);
            rv1    = pop_m && (head == 1);

            check("mem_req",   32'(mem_bus.req), 32'(req_m));
            check("mem_addr",  mem_bus.addr, addr_m);
            check("m0_gnt",    32'(m0_bus.gnt), 32'(gnt_m && sel == 0));
            check("m1_gnt",    32'(m1_bus.gnt), 32'(gnt_m && sel == 1));
            check("m0_rvalid", 32'(m0_bus.rvalid), 32'(rv0));
            check("m1_rvalid", 32'(m1_bus.rvalid), 32'(rv1));
            check("m0_rdata",  m0_bus.rdata, rv0 ? cur.rd : 32'h0);
            check("m1_rdata",  m1_bus.rdata, rv1 ? cur.rd : 32'h0);
            check("outstanding", 32'(outstanding_o), 32'(q.size()));
            check("err",       32'(err_o), 32'(err_m));

            if (cur.chk) begin
                check("lit_gnt",  32'({m1_bus.gnt, m0_bus.gnt}), 32'(cur.egnt));
                check("lit_rv",   32'({m1_bus.rvalid, m0_bus.rvalid}), 32'(cur.erv));
                check("lit_cnt",  32'(outstanding_o), 32'(cur.ecnt));
                check("lit_err",  32'(err_o), 32'(cur.eerr));
                check("lit_req",  32'(mem_bus.req), 32'(cur.ereq));
                check("lit_addr", mem_bus.addr, cur.eaddr);
            end

            // Advance the model to the state after the coming clock edge.
            if (cur.rst) begin
                q.delete();
                rr_m = 0;
                lock_m = -1;
                err_m = 1'b0;
            end else begin
                if (cur.rv && q.size() == 0) err_m = 1'b1;
                if (pop_m) void'(q.pop_front());
                if (gnt_m) begin
                    q.push_back(sel);
                    rr_m = 1 - sel;
                end
                if (lock_m >= 0) begin
                    if (!sreq) err_m = 1'b1;
                    if (!sreq || cur.g) lock_m = -1;
                end else if (req_m && !cur.g) begin
                    lock_m = sel;
                end
            end
        end
    end

    initial begin
        m0_bus.req = 0; m0_bus.addr = 0;
        m1_bus.req = 0; m1_bus.addr = 0;
        mem_bus.gnt = 0; mem_bus.rvalid = 0; mem_bus.rdata = 0;

        // Reset with m0 requesting: everything must stay quiet.
        add(1, 1, 'h80, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0);
        add(1, 1, 'h80, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0);
        // Only m0: 0x80 then 0x0, rvalid one cycle after each grant.
        add(0, 1, 'h80, 0, 0, 1, 0, 0,       1, 2'b01, 2'b00, 0, 0, 1, 'h80);
        add(0, 1, 'h0,  0, 0, 1, 1, 'h1111,  1, 2'b01, 2'b01, 1, 0, 1, 'h0);
        add(0, 0, 0,    0, 0, 0, 1, 'h2222,  1, 2'b00, 2'b01, 1, 0, 0, 0);
        idle(0, 0, 0);
        // Both masters continuously: m0, m1, m0, m1 after reset.
        idle(1, 0, 0); idle(1, 0, 0);
        add(0, 1, 'h4, 1, 'h48, 1, 0, 0,     1, 2'b01, 2'b00, 0, 0, 1, 'h4);
        add(0, 1, 'h4, 1, 'h48, 1, 1, 'hA0,  1, 2'b10, 2'b01, 1, 0, 1, 'h48);
        add(0, 1, 'h4, 1, 'h48, 1, 1, 'hA1,  1, 2'b01, 2'b10, 1, 0, 1, 'h4);
        add(0, 1, 'h4, 1, 'h48, 1, 1, 'hA2,  1, 2'b10, 2'b01, 1, 0, 1, 'h48);
        add(0, 0, 0,   0, 0,    0, 1, 'hA3,  1, 2'b00, 2'b10, 1, 0, 0, 0);
        idle(0, 0, 0);
        // Grant withheld 3 cycles with m0 locked while m1 raises req.
        add(0, 1, 'h4, 0, 0,    0, 0, 0,     1, 2'b00, 2'b00, 0, 0, 1, 'h4);
        add(0, 1, 'h4, 1, 'h48, 0, 0, 0,     1, 2'b00, 2'b00, 0, 0, 1, 'h4);
        add(0, 1, 'h4, 1, 'h48, 0, 0, 0,     1, 2'b00, 2'b00, 0, 0, 1, 'h4);
        add(0, 1, 'h4, 1, 'h48, 1, 0, 0,     1, 2'b01, 2'b00, 0, 0, 1, 'h4);
        add(0, 0, 0,   1, 'h48, 1, 1, 'hB0,  1, 2'b10, 2'b01, 1, 0, 1, 'h48);
        add(0, 0, 0,   0, 0,    0, 1, 'hB1,  1, 2'b00, 2'b10, 1, 0, 0, 0);
        // Fill to MAX_OUTSTANDING, stall, rvalid re-enables the request.
        add(0, 1, 'h100, 0, 0,     1, 0, 0,     1, 2'b01, 2'b00, 0, 0, 1, 'h100);
        add(0, 1, 'h104, 1, 'h200, 1, 0, 0,     1, 2'b10, 2'b00, 1, 0, 1, 'h200);
        add(0, 1, 'h104, 1, 'h200, 1, 0, 0,     1, 2'b00, 2'b00, 2, 0, 0, 0);
        add(0, 1, 'h104, 1, 'h200, 1, 0, 0,     1, 2'b00, 2'b00, 2, 0, 0, 0);
        add(0, 1, 'h104, 1, 'h200, 1, 1, 'hC0,  1, 2'b01, 2'b01, 2, 0, 1, 'h104);
        add(0, 0, 0,     0, 0,     0, 1, 'hC1,  1, 2'b00, 2'b10, 2, 0, 0, 0);
        // Grant + rvalid together at count 1.
        add(0, 0, 0,     1, 'h300, 1, 1, 'hC2,  1, 2'b10, 2'b01, 1, 0, 1, 'h300);
        add(0, 0, 0,     0, 0,     0, 1, 'hC3,  1, 2'b00, 2'b10, 1, 0, 0, 0);
        idle(0, 0, 0);
        // Spurious rvalid, then reset mid-transaction and a late rvalid.
        add(0, 0, 0, 0, 0, 0, 1, 'hDEAD,     1, 2'b00, 2'b00, 0, 0, 0, 0);
        idle(0, 0, 1);
        add(0, 1, 'h10, 0, 0, 1, 0, 0,       1, 2'b01, 2'b00, 0, 1, 1, 'h10);
        add(1, 1, 'h10, 0, 0, 0, 0, 0,       0, 2'b00, 2'b00, 0, 0, 0, 0);
        idle(1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 'hBEEF,     1, 2'b00, 2'b00, 0, 0, 0, 0);
        idle(0, 0, 1);
        // Locked master withdraws its request.
        idle(1, 0, 1); idle(1, 0, 0);
        add(0, 1, 'h20, 0, 0,    0, 0, 0,    1, 2'b00, 2'b00, 0, 0, 1, 'h20);
        add(0, 0, 0,    1, 'h40, 1, 0, 0,    1, 2'b00, 2'b00, 0, 0, 0, 0);
        add(0, 0, 0,    1, 'h40, 1, 0, 0,    1, 2'b10, 2'b00, 0, 1, 1, 'h40);
        add(0, 0, 0,    0, 0,    0, 1, 'hD0, 1, 2'b00, 2'b10, 1, 1, 0, 0);
        idle(0, 0, 1);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            cur = vecs[i];
            rst = cur.rst;
            m0_bus.req = cur.r0;  m0_bus.addr = cur.a0;
            m1_bus.req = cur.r1;  m1_bus.addr = cur.a1;
            mem_bus.gnt = cur.g;  mem_bus.rvalid = cur.rv;  mem_bus.rdata = cur.rd;
            active = 1'b1;
            $display("vec %0d: rst=%0d req=%0d%0d gnt_in=%0d rvalid_in=%0d", i,
                     cur.rst, cur.r1, cur.r0, cur.g, cur.rv);
        end
        @(posedge clk);
        #1;
        active = 1'b0;
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
